// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with valid/ready input.
// Frame: start bit, DATA_BITS data bits (LSB first), optional parity bit,
// STOP_BITS stop bits. Every bit lasts CLK_DIV clocks.
// Optional build macro UART_TX_HOLD_BUF_EN adds a one-entry holding register
// so that the producer can hand over the next word while a frame is on the line.
module uart_tx_frame #(
    parameter int CLK_DIV     = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_pin
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);
    // Mode 3 (and anything else) is treated as "no parity".
    localparam bit HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;

    logic                 accept;
    logic                 have_word;
    logic [DATA_BITS-1:0] next_word;
    logic                 bit_end;
    logic                 frame_end;
    logic                 start_frame;

    // Parity over the captured word: odd mode makes the total count of ones odd.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
        case (PARITY_MODE)
            1:       return ~^word;
            2:       return ^word;
            default: return 1'b0;
        endcase
    endfunction

    assign accept    = tx_valid && tx_ready;
    assign bit_end   = (state != IDLE) && (baud_cnt == BAUD_LAST);
    assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);

`ifdef UART_TX_HOLD_BUF_EN
    logic                 hold_full;
    logic [DATA_BITS-1:0] hold_data;

    // A parked word always goes out before a word offered on the same cycle.
    assign tx_ready  = !hold_full;
    assign have_word = hold_full || accept;
    assign next_word = hold_full ? hold_data : tx_data;

    // Holding register occupancy: filled by an accept that cannot go straight
    // to the shift register, emptied when its word starts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
        end else if (start_frame && hold_full) begin
            hold_full <= accept;
        end else if (accept && !start_frame) begin
            hold_full <= 1'b1;
        end
    end

    // Holding register payload; contents only matter while hold_full is set.
    always_ff @(posedge clk) begin
        if (accept && (hold_full || !start_frame)) begin
            hold_data <= tx_data;
        end
    end
`else
    // Ready also during the tx_done cycle so a held-valid producer starts the
    // next frame directly after the final stop bit, with no idle gap.
    assign tx_ready  = !tx_busy || tx_done;
    assign have_word = accept;
    assign next_word = tx_data;
`endif

    assign start_frame = have_word && ((state == IDLE) || frame_end);

    // Frame sequencer: state, baud/bit counters and all registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_pin   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (start_frame) begin
                state    <= START;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                tx_pin   <= 1'b0;
                tx_busy  <= 1'b1;
            end else if (state == IDLE) begin
                baud_cnt <= '0;
            end else if (bit_end) begin
                baud_cnt <= '0;
                case (state)
                    START: begin
                        state  <= DATA;
                        tx_pin <= shift_reg[0];
                    end
                    DATA: begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                state  <= PARITY;
                                tx_pin <= parity_bit;
                            end else begin
                                state  <= STOP;
                                tx_pin <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_pin  <= shift_reg[0];
                        end
                    end
                    PARITY: begin
                        state  <= STOP;
                        tx_pin <= 1'b1;
                    end
                    STOP: begin
                        if (bit_cnt == STOP_LAST) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            tx_busy <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
                // Registered strobe: raised one cycle early so it lines up
                // with the last cycle of the final stop bit.
                if ((state == STOP) && (bit_cnt == STOP_LAST) && (baud_cnt == BAUD_PRE)) begin
                    tx_done <= 1'b1;
                end
            end
        end
    end

    // Data path: capture the word and its parity at frame start, then shift
    // one bit out per bit time so shift_reg[0] is always the next data bit.
    always_ff @(posedge clk) begin
        if (start_frame) begin
            shift_reg  <= next_word;
            parity_bit <= parity_of(next_word);
        end else if (bit_end && ((state == START) || (state == DATA))) begin
            shift_reg <= shift_reg >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with four parameter sets at CLK_DIV=4:
// 8N1, 8O1, 8E1 and 7N2. Expected line patterns are hand-computed constants,
// bit i of a pattern is the i-th bit time on the line (start bit first).
module tb_uart_tx_frame;

    localparam int CDIV = 4;

`ifdef UART_TX_HOLD_BUF_EN
    localparam bit RDY_MID = 1'b1;
`else
    localparam bit RDY_MID = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld  [4];
    logic [7:0] dat  [3];
    logic [6:0] dat7;
    logic       rdy  [4];
    logic       busy [4];
    logic       done [4];
    logic       pin  [4];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(vld[0]), .tx_data(dat[0]),
        .tx_ready(rdy[0]), .tx_busy(busy[0]), .tx_done(done[0]), .tx_pin(pin[0]));

    uart_tx_frame #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(vld[1]), .tx_data(dat[1]),
        .tx_ready(rdy[1]), .tx_busy(busy[1]), .tx_done(done[1]), .tx_pin(pin[1]));

    uart_tx_frame #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(vld[2]), .tx_data(dat[2]),
        .tx_ready(rdy[2]), .tx_busy(busy[2]), .tx_done(done[2]), .tx_pin(pin[2]));

    uart_tx_frame #(.CLK_DIV(CDIV), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst_n(rst_n), .tx_valid(vld[3]), .tx_data(dat7),
        .tx_ready(rdy[3]), .tx_busy(busy[3]), .tx_done(done[3]), .tx_pin(pin[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int k, input logic [7:0] w);
        if (k == 3) dat7 = w[6:0];
        else        dat[k] = w;
    endtask

    // Present one word for a single accept, then withdraw valid.
    task automatic accept_word(input int k, input logic [7:0] w);
        @(negedge clk);
        vld[k] = 1'b1;
        set_word(k, w);
        chk($sformatf("ready_before_accept%0d", k), rdy[k], 1'b1);
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
    endtask

    // Check frame cycles j0..j1 (cycle 1 = first cycle after the accept edge).
    task automatic watch(input int k, input int nbits, input logic [15:0] exp,
                         input int j0, input int j1, input bit rdy_mid, input bit rdy_end);
        int last;
        last = nbits * CDIV;
        for (int j = j0; j <= j1; j++) begin
            @(negedge clk);
            chk($sformatf("pin%0d_c%0d", k, j), pin[k], exp[(j - 1) / CDIV]);
            chk($sformatf("busy_done%0d_c%0d", k, j), {busy[k], done[k]}, {1'b1, (j == last)});
            chk($sformatf("ready%0d_c%0d", k, j), rdy[k], (j == last) ? rdy_end : rdy_mid);
        end
    endtask

    task automatic idle_chk(input int k, input string tag);
        @(negedge clk);
        chk(tag, {pin[k], rdy[k], busy[k], done[k]}, 4'b1100);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) vld[i] = 1'b0;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;
        dat7 = 7'h00;

        // Reset, then 20 idle cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) idle_chk(0, $sformatf("idle_c%0d", c));

        // 0x55, 8N1: 0,1,0,1,0,1,0,1,0,1
        accept_word(0, 8'h55);
        watch(0, 10, 16'h02AA, 1, 40, RDY_MID, 1'b1);
        idle_chk(0, "idle_after_55");

        // 0x07 odd parity -> parity 0
        accept_word(1, 8'h07);
        watch(1, 11, 16'h040E, 1, 44, RDY_MID, 1'b1);
        idle_chk(1, "idle_after_odd");

        // 0x07 even parity -> parity 1
        accept_word(2, 8'h07);
        watch(2, 11, 16'h060E, 1, 44, RDY_MID, 1'b1);
        idle_chk(2, "idle_after_even");

        // 0x7F, 7 data bits, 2 stop bits
        accept_word(3, 8'h7F);
        watch(3, 10, 16'h03FE, 1, 40, RDY_MID, 1'b1);
        idle_chk(3, "idle_after_7n2");

`ifdef UART_TX_HOLD_BUF_EN
        // Back-to-back through the holding register
        @(negedge clk);
        vld[0] = 1'b1;
        dat[0] = 8'hA5;
        chk("b2b_ready0", rdy[0], 1'b1);
        @(posedge clk);
        #1;
        dat[0] = 8'h3C;
        @(negedge clk);
        chk("b2b_ready_reassert", rdy[0], 1'b1);
        chk("b2b_pin_c1", pin[0], 1'b0);
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        watch(0, 10, 16'h034A, 2, 40, 1'b0, 1'b0);
        watch(0, 10, 16'h0278, 1, 40, 1'b1, 1'b1);
        idle_chk(0, "idle_after_b2b");
`else
        // Back-to-back with valid held: second start bit right after tx_done
        @(negedge clk);
        vld[0] = 1'b1;
        dat[0] = 8'hA5;
        chk("b2b_ready0", rdy[0], 1'b1);
        @(posedge clk);
        #1;
        dat[0] = 8'h3C;
        watch(0, 10, 16'h034A, 1, 40, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        watch(0, 10, 16'h0278, 1, 40, 1'b0, 1'b1);
        idle_chk(0, "idle_after_b2b");

        // Valid raised mid-frame: not taken until the tx_done cycle
        accept_word(0, 8'h0F);
        watch(0, 10, 16'h021E, 1, 20, 1'b0, 1'b1);
        vld[0] = 1'b1;
        dat[0] = 8'hF0;
        watch(0, 10, 16'h021E, 21, 40, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        watch(0, 10, 16'h03E0, 1, 40, 1'b0, 1'b1);
        idle_chk(0, "idle_after_midframe");
`endif

        // Reset in the middle of a frame of zeros
        accept_word(0, 8'h00);
        watch(0, 10, 16'h0200, 1, 10, RDY_MID, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pin_async", pin[0], 1'b1);
        chk("rst_busy_async", busy[0], 1'b0);
        chk("rst_ready_async", rdy[0], 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_done_c%0d", c), done[0], 1'b0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 44; c++) idle_chk(0, $sformatf("post_rst_c%0d", c));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
